// File: rtl/rx_frame_assembler_if.sv
// Bundles the rx-side strobes and the consumer-side frame read port of rx_frame_assembler.
// The master modport belongs to the side that drives the rx strobes and reads frames; the slave modport belongs to the assembler.
interface rx_frame_assembler_if #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
  logic             soc;
  logic             eoc;
  logic [7:0]       data;
  logic [2:0]       data_bits;
  logic             data_valid;
  logic             sequence_error;
  logic             parity_error;
  logic             frame_ack;
  logic [LEN_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             frame_valid;
  logic [LEN_W-1:0] frame_len;
  logic [2:0]       frame_bits;
  logic             err_parity;
  logic             err_sequence;
  logic             err_overflow;
  logic             crc_ok;
  logic             frame_dropped;

  modport master (
    output soc, eoc, data, data_bits, data_valid, sequence_error, parity_error,
    output frame_ack, rd_addr,
    input  rd_data, frame_valid, frame_len, frame_bits,
    input  err_parity, err_sequence, err_overflow, crc_ok, frame_dropped
  );

  modport slave (
    input  soc, eoc, data, data_bits, data_valid, sequence_error, parity_error,
    input  frame_ack, rd_addr,
    output rd_data, frame_valid, frame_len, frame_bits,
    output err_parity, err_sequence, err_overflow, crc_ok, frame_dropped
  );
endinterface

// File: rtl/rx_frame_assembler.sv
// Buffers one received frame, tracks its errors and CRC_A residue, and holds it until frame_ack.
// Optional CRC checker: define RX_FRAME_CRC_EN to build it; otherwise crc_ok is tied low.
module rx_frame_assembler #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rx_frame_assembler_if.slave  bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       bits_q, bits_d;
  logic             err_par_q, err_par_d;
  logic             err_seq_q, err_seq_d;
  logic             err_ovf_q, err_ovf_d;
  logic             valid_q, valid_d;
  logic             dropped_q, dropped_d;
  logic             crc_ok_q, crc_ok_d;
  logic [7:0]       buf_q [MAX_BYTES];
  logic [7:0]       buf_d [MAX_BYTES];

  logic             restart_s;
  logic             wr_a_en_s, wr_b_en_s;
  logic [LEN_W-1:0] wr_a_idx_s, wr_b_idx_s;
  logic             crc_good_s;
  logic [7:0]       rd_data_s;

`ifdef RX_FRAME_CRC_EN
  localparam logic [15:0] CRC_INIT = 16'h6363;

  logic [15:0] crc_q, crc_d;

  // Reflected CRC_A step (poly 0x8408), one byte consumed LSB first.
  function automatic logic [15:0] crc_a_update(input logic [15:0] crc_in, input logic [7:0] byte_in);
    logic [15:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if ((c[0] ^ byte_in[b]) == 1'b1) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  // Next-state, frame bookkeeping and buffer write requests.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bits_d     = bits_q;
    err_par_d  = err_par_q;
    err_seq_d  = err_seq_q;
    err_ovf_d  = err_ovf_q;
    dropped_d  = 1'b0;
    restart_s  = 1'b0;
    wr_a_en_s  = 1'b0;
    wr_a_idx_s = len_q;
    wr_b_en_s  = 1'b0;
    wr_b_idx_s = len_q;
`ifdef RX_FRAME_CRC_EN
    crc_d      = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.soc) begin
          restart_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (bus.soc) begin
          restart_s = 1'b1;
        end else begin
          // Once a line error is flagged the remaining bytes of the frame are not trusted.
          if (bus.data_valid && !(err_par_q || err_seq_q)) begin
            if (len_q < MAX_LEN) begin
              wr_a_en_s = 1'b1;
              len_d     = len_q + LEN_W'(1);
`ifdef RX_FRAME_CRC_EN
              crc_d     = crc_a_update(crc_q, bus.data);
`endif
            end else begin
              err_ovf_d = 1'b1;
            end
          end else begin
            wr_a_en_s = 1'b0;
          end
          err_par_d = err_par_q | bus.parity_error;
          err_seq_d = err_seq_q | bus.sequence_error;
          if (bus.eoc) begin
            bits_d  = bus.data_bits;
            state_d = ST_HOLD;
            if ((bus.data_bits != 3'd0) && (len_d < MAX_LEN)) begin
              wr_b_en_s  = 1'b1;
              wr_b_idx_s = len_d;
              len_d      = len_d + LEN_W'(1);
            end else begin
              wr_b_en_s = 1'b0;
            end
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_HOLD: begin
        if (bus.frame_ack) begin
          if (bus.soc) begin
            restart_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.soc) begin
          state_d   = ST_DISCARD;
          dropped_d = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (bus.frame_ack) begin
          state_d = ST_IDLE;
        end else if (bus.eoc) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart_s) begin
      state_d   = ST_RECV;
      len_d     = '0;
      bits_d    = 3'd0;
      err_par_d = 1'b0;
      err_seq_d = 1'b0;
      err_ovf_d = 1'b0;
      wr_a_en_s = 1'b0;
      wr_b_en_s = 1'b0;
`ifdef RX_FRAME_CRC_EN
      crc_d     = CRC_INIT;
`endif
    end else begin
      restart_s = 1'b0;
    end

`ifdef RX_FRAME_CRC_EN
    crc_good_s = (crc_d == 16'h0000) && (bits_d == 3'd0) && (len_d >= LEN_W'(3)) &&
                 !(err_par_d || err_seq_d || err_ovf_d);
`else
    crc_good_s = 1'b0;
`endif

    // The held frame stays valid while a newer frame is being discarded.
    valid_d = (state_d == ST_HOLD) || (state_d == ST_DISCARD);
    if ((state_q == ST_RECV) && (state_d == ST_HOLD)) begin
      crc_ok_d = crc_good_s;
    end else if (valid_d) begin
      crc_ok_d = crc_ok_q;
    end else begin
      crc_ok_d = 1'b0;
    end
  end

  // Buffer next contents: at most one full byte plus one partial byte per cycle.
  always_comb begin
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (wr_a_en_s && (wr_a_idx_s == LEN_W'(i))) begin
        buf_d[i] = bus.data;
      end else if (wr_b_en_s && (wr_b_idx_s == LEN_W'(i))) begin
        buf_d[i] = bus.data;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
  end

  // Combinational read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      rd_data_s = (bus.rd_addr == LEN_W'(i)) ? buf_q[i] : rd_data_s;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      bits_q    <= 3'd0;
      err_par_q <= 1'b0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      bits_q    <= bits_d;
      err_par_q <= err_par_d;
      err_seq_q <= err_seq_d;
      err_ovf_q <= err_ovf_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

`ifdef RX_FRAME_CRC_EN
  // CRC_A accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  // Frame buffer storage, intentionally without reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_BYTES; i++) begin
      buf_q[i] <= buf_d[i];
    end
  end

  assign bus.rd_data       = rd_data_s;
  assign bus.frame_valid   = valid_q;
  assign bus.frame_len     = len_q;
  assign bus.frame_bits    = bits_q;
  assign bus.err_parity    = err_par_q;
  assign bus.err_sequence  = err_seq_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.crc_ok        = crc_ok_q;
  assign bus.frame_dropped = dropped_q;

endmodule
